// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: N-input round-robin arbiter sharing one valid/ready channel.
//
// A grant stays locked to a requester until it sends a beat with last=1, so
// multi-beat bursts are never interleaved. The output is a single registered
// stage with full throughput (pop and refill in the same cycle).
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   up_valid   - per-requester valid (N)
//   up_data    - per-requester data, requester i at [i*DW +: DW]
//   up_last    - per-requester end-of-burst flag (N)
//   up_ready   - per-requester ready, at most one bit high (N)
//   down_valid - output beat valid (registered)
//   down_data  - output beat data (registered)
//   down_last  - output beat last flag (registered)
//   down_src   - index of requester that produced the output beat (registered)
//   down_ready - downstream ready
module rr_stream_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_valid,
  input  logic [N*DW-1:0] up_data,
  input  logic [N-1:0]    up_last,
  output logic [N-1:0]    up_ready,
  output logic            down_valid,
  output logic [DW-1:0]   down_data,
  output logic            down_last,
  output logic [SW-1:0]   down_src,
  input  logic            down_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_id_q, lock_id_d;
  logic          down_valid_q, down_valid_d;
  logic [DW-1:0] down_data_q, down_data_d;
  logic          down_last_q, down_last_d;
  logic [SW-1:0] down_src_q, down_src_d;

  logic          accept;
  logic [N-1:0]  gnt;
  logic          xfer;
  logic [SW-1:0] xfer_id;
  logic [DW-1:0] xfer_data;
  logic          xfer_last;

  assign accept = !down_valid_q || down_ready;

  // Grant depends only on lock state, pointer and up_valid, never on data/last.
  always_comb begin
    logic          found;
    logic [SW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (lock_q) begin
      // Held even if the locked requester drops valid: that is the lock bubble.
      gnt[lock_id_q] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = SW'((32'(ptr_q) + k) % N);
        if (!found && up_valid[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign up_ready = accept ? (gnt & up_valid) : '0;
  assign xfer     = |up_ready;

  // up_ready is one-hot, so the last match is the only match.
  always_comb begin
    xfer_id   = '0;
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (up_ready[i]) begin
        xfer_id   = SW'(i);
        xfer_data = up_data[i*DW +: DW];
        xfer_last = up_last[i];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_last_d  = down_last_q;
    down_src_d   = down_src_q;

    // Pop clears valid only; payload registers keep their last value.
    if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end

    if (xfer) begin
      down_valid_d = 1'b1;
      down_data_d  = xfer_data;
      down_last_d  = xfer_last;
      down_src_d   = xfer_id;
      if (xfer_last) begin
        lock_d = 1'b0;
        ptr_d  = (32'(xfer_id) == N - 1) ? '0 : xfer_id + 1'b1;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = xfer_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_last_q  <= 1'b0;
      down_src_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_last_q  <= down_last_d;
      down_src_q   <= down_src_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_last  = down_last_q;
  assign down_src   = down_src_q;

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- N-input round-robin arbiter that shares one downstream valid/ready channel among N upstream valid/ready requesters.
- Supports multi-beat bursts: a grant is locked until the granted requester sends a beat with last=1.
- The output is a valid-registered pipeline stage (one beat of storage). It drops directly in front of the existing handshake pipeline chains as their shared master.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- DW, 16, data width per requester.
- SW, derived as clog2(N) (minimum 1), width of the source-ID field; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- up_valid  in  N  per-requester valid.
- up_data  in  N*DW  per-requester data; requester i uses bits [i*DW +: DW].
- up_last  in  N  per-requester end-of-burst flag; sampled only with that requester's beat.
- up_ready  out  N  per-requester ready; at most one bit high per cycle.
- down_valid  out  1  output beat valid; driven directly by a register.
- down_data  out  DW  output beat data; driven directly by a register.
- down_last  out  1  last flag of the output beat; registered.
- down_src  out  SW  index of the requester that produced the output beat; registered.
- down_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - down_valid=0, down_data=0, down_last=0, down_src=0.
  - Round-robin pointer ptr=0, lock=0, lock_id=0.
  - The register state takes effect immediately, without waiting for clk.
- Stage accept: accept = !down_valid | down_ready (combinational).
- Grant selection (combinational, one-hot gnt):
  - If lock=1: gnt = onehot(lock_id), regardless of up_valid[lock_id].
  - If lock=0: gnt = the first i with up_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps modulo N). If no requester is valid, gnt=0.
- Ready: up_ready = gnt & up_valid when accept=1, else 0.
  - Never assert ready to a requester that is not valid.
  - up_ready never depends combinationally on any up_data or up_last bit.
- Transfer from requester i: up_valid[i] & up_ready[i]. Registered on that clock edge:
  - down_data <= up_data[i], down_last <= up_last[i], down_src <= i, down_valid <= 1.
  - If up_last[i]=1: lock <= 0, ptr <= (i+1) mod N.
  - If up_last[i]=0: lock <= 1, lock_id <= i; ptr is unchanged.
- Pop: down_valid & down_ready. If there is a pop and no transfer in the same cycle, down_valid <= 0. down_data, down_last and down_src hold their values; they are not cleared.
- Simultaneous pop and transfer: the new beat replaces the old one and down_valid stays 1. This sustains full throughput of one beat per cycle.
- Backpressure: while down_valid=1 and down_ready=0, all up_ready=0 and all output registers hold.
- Latency: a beat accepted at edge k is visible on down_* right after edge k. There is no combinational path from up_* to down_*.
- Lock bubble: while locked, if the locked requester deasserts valid, the channel idles. No other requester is granted until that requester delivers a last=1 beat.
- Single-beat requests (last=1 on every beat) give pure round-robin: each requester is served at most once per N grants while others are waiting.
- Reset mid-burst: lock and ptr are cleared, and any beat held in the stage is discarded (down_valid=0). The next grant goes to the lowest-index valid requester.
- Upstream contract: once a requester asserts valid, it holds valid, data and last stable until it receives ready. The arbiter is not required to tolerate violations.

Test Plan:
1. Reset, then all four requesters valid with last=1 and down_ready=1 → down_src sequence 0,1,2,3,0,1 on consecutive cycles; down_valid stays 1 throughout; up_ready rotates one-hot 0001,0010,0100,1000.
2. Requester 1 sends a 3-beat burst (data 0xA001, 0xA002, 0xA003, last on beat 3) while requester 2 is continuously valid → three beats from src 1 appear back-to-back, then a src 2 beat; up_ready[2]=0 throughout the burst.
3. Lock bubble: requester 0 sends beat 0x0011 (last=0), then drops valid for 3 cycles while requester 3 stays valid → down_valid=0 for those cycles and up_ready[3]=0; when requester 0 sends 0x0012 (last=1), the next grant goes to src 3.
4. Backpressure: hold down_ready=0 for 4 cycles with a beat held and requester 2 valid → down_data, down_src and down_last are stable, up_ready=0; on the first cycle down_ready=1, the pop and the new accept happen together and down_valid remains 1.
5. Idle: no requester valid → up_ready=0, and after any held beat is popped, down_valid=0; ptr is unchanged, checked by making requesters 2 and 0 valid afterwards, which must grant in the order implied by the preserved ptr.
6. Assert rst low asynchronously between clock edges in the middle of requester 1's burst → down_valid falls to 0 immediately; after release, the lowest-index valid requester (0) is granted first.
